utlb: RTL

Micro-TLB sitting directly upstream of `tlb` search port 0, between the fetch/memory stage and the joint TLB. It caches the most recent virtual-to-physical translations for one port. On a miss it makes one query to `tlb`, fills an entry, and returns the physical address together with the MIPS TLB exception flags. Unmapped kseg0/kseg1 addresses bypass translation entirely.

---
 rtl/utlb_pkg.sv | 34 +++
 rtl/utlb_cam.sv | 68 ++++++
 rtl/utlb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/utlb_pkg.sv
// utlb_pkg: shared types and constants for the micro-TLB.
//   state_e  : controller states (IDLE / WALK / RESP)
//   entry_t  : one cached translation {valid, vpn, asid, pfn, c, d}
//   KSEG constants and a helper that recognises the unmapped segments.
package utlb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Top three vaddr bits of the two fixed-mapping kernel segments.
    localparam logic [2:0] SEG_KSEG0 = 3'b100;
    localparam logic [2:0] SEG_KSEG1 = 3'b101;

    // Cacheability attribute value meaning "cacheable noncoherent".
    localparam logic [2:0] C_CACHED = 3'd3;

    typedef struct packed {
        logic        valid;
        logic [19:0] vpn;
        logic [7:0]  asid;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
    } entry_t;

    // True for kseg0/kseg1, which bypass translation.
    function automatic logic is_unmapped(input logic [2:0] seg);
        return (seg == SEG_KSEG0) || (seg == SEG_KSEG1);
    endfunction

endpackage

// File: rtl/utlb_cam.sv
// utlb_cam: fully associative translation store for the micro-TLB.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   i_vpn, i_asid              - lookup key (combinational match)
//   o_hit_vec                  - one-hot match vector
//   o_hit_pfn/o_hit_c/o_hit_d  - data of the matching entry (0 on miss)
//   i_fill, i_fill_idx, i_fill_* - write one entry and mark it valid
//   i_flush                    - clear every valid bit at the next edge
module utlb_cam
    import utlb_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int PTR_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        i_vpn,
    input  logic [7:0]         i_asid,
    output logic [ENTRIES-1:0] o_hit_vec,
    output logic [19:0]        o_hit_pfn,
    output logic [2:0]         o_hit_c,
    output logic               o_hit_d,
    input  logic               i_fill,
    input  logic [PTR_W-1:0]   i_fill_idx,
    input  logic [19:0]        i_fill_vpn,
    input  logic [7:0]         i_fill_asid,
    input  logic [19:0]        i_fill_pfn,
    input  logic [2:0]         i_fill_c,
    input  logic               i_fill_d,
    input  logic               i_flush
);

    entry_t r_entry [ENTRIES];

    // Parallel match; fills only happen on a miss so at most one entry hits,
    // which makes OR-ing the masked entry data a valid one-hot mux.
    always_comb begin
        o_hit_vec = '0;
        o_hit_pfn = 20'h0_0000;
        o_hit_c   = 3'd0;
        o_hit_d   = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_entry[i].valid && (r_entry[i].vpn == i_vpn) && (r_entry[i].asid == i_asid)) begin
                o_hit_vec[i] = 1'b1;
                o_hit_pfn    = o_hit_pfn | r_entry[i].pfn;
                o_hit_c      = o_hit_c | r_entry[i].c;
                o_hit_d      = o_hit_d | r_entry[i].d;
            end else begin
                o_hit_vec[i] = 1'b0;
            end
        end
    end

    // Entry storage: reset, then flush (wins over fill), then fill.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) begin
                r_entry[i] <= '0;
            end else if (i_flush) begin
                r_entry[i].valid <= 1'b0;
            end else if (i_fill && (i_fill_idx == PTR_W'(i))) begin
                r_entry[i] <= '{valid: 1'b1, vpn: i_fill_vpn, asid: i_fill_asid,
                                pfn: i_fill_pfn, c: i_fill_c, d: i_fill_d};
            end
        end
    end

endmodule

// File: rtl/utlb.sv
// utlb: micro-TLB in front of joint-TLB search port 0.
// Caches recent translations; on a miss performs one joint-TLB query (WALK),
// fills a round-robin victim on success, and returns paddr plus MIPS TLB
// exception flags. kseg0/kseg1 bypass translation.
// Ports:
//   req_*   - request handshake (req_ready high only in IDLE)
//   resp_*  - registered response, held until resp_ready
//   s_*     - joint-TLB query (outputs) and same-cycle result (inputs)
//   flush   - invalidate all cached entries
// Optional build macro UTLB_PERF_EN adds perf_hit / perf_miss counters.
module utlb
    import utlb_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic [7:0]  req_asid,
    input  logic        req_store,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_paddr,
    output logic        resp_refill,
    output logic        resp_invalid,
    output logic        resp_modified,
    output logic        resp_cached,
`ifdef UTLB_PERF_EN
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss,
`endif
    output logic [18:0] s_vpn2,
    output logic        s_odd_page,
    output logic [7:0]  s_asid,
    input  logic        s_found,
    input  logic [19:0] s_pfn,
    input  logic [2:0]  s_c,
    input  logic        s_d,
    input  logic        s_v,
    input  logic        flush
);

    localparam int PTR_W = $clog2(ENTRIES);

    state_e             r_state;
    logic [31:0]        r_vaddr;
    logic [7:0]         r_asid;
    logic               r_store;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic [31:0]        r_paddr;
    logic               r_refill;
    logic               r_invalid;
    logic               r_modified;
    logic               r_cached;

    state_e             w_next_state;
    logic               w_capture;
    logic               w_load_resp;
    logic               w_fill;
    logic               w_hit_accept;
    logic [31:0]        w_paddr;
    logic               w_refill;
    logic               w_invalid;
    logic               w_modified;
    logic               w_cached;
    logic [ENTRIES-1:0] w_hit_vec;
    logic               w_hit;
    logic [19:0]        w_hit_pfn;
    logic [2:0]         w_hit_c;
    logic               w_hit_d;

    utlb_cam #(.ENTRIES(ENTRIES), .PTR_W(PTR_W)) u_cam (
        .clk         (clk),
        .reset       (reset),
        .i_vpn       (req_vaddr[31:12]),
        .i_asid      (req_asid),
        .o_hit_vec   (w_hit_vec),
        .o_hit_pfn   (w_hit_pfn),
        .o_hit_c     (w_hit_c),
        .o_hit_d     (w_hit_d),
        .i_fill      (w_fill),
        .i_fill_idx  (r_ptr),
        .i_fill_vpn  (r_vaddr[31:12]),
        .i_fill_asid (r_asid),
        .i_fill_pfn  (s_pfn),
        .i_fill_c    (s_c),
        .i_fill_d    (s_d),
        .i_flush     (flush)
    );

    assign w_hit = |w_hit_vec;

    // Query always reflects the registered request.
    assign s_vpn2     = r_vaddr[31:13];
    assign s_odd_page = r_vaddr[12];
    assign s_asid     = r_asid;

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_paddr    = r_paddr;
    assign resp_refill   = r_refill;
    assign resp_invalid  = r_invalid;
    assign resp_modified = r_modified;
    assign resp_cached   = r_cached;

    // Next-state, response computation and fill control.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_load_resp  = 1'b0;
        w_fill       = 1'b0;
        w_hit_accept = 1'b0;
        w_paddr      = 32'h0000_0000;
        w_refill     = 1'b0;
        w_invalid    = 1'b0;
        w_modified   = 1'b0;
        w_cached     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_capture = 1'b1;
                    if (is_unmapped(req_vaddr[31:29])) begin
                        w_load_resp  = 1'b1;
                        w_paddr      = {3'b000, req_vaddr[28:0]};
                        w_cached     = ~req_vaddr[29];
                        w_next_state = ST_RESP;
                    end else if (w_hit) begin
                        w_load_resp  = 1'b1;
                        w_hit_accept = 1'b1;
                        w_paddr      = {w_hit_pfn, req_vaddr[11:0]};
                        w_cached     = (w_hit_c == C_CACHED);
                        w_modified   = req_store & ~w_hit_d;
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_WALK;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WALK: begin
                w_load_resp  = 1'b1;
                w_next_state = ST_RESP;
                if (!s_found) begin
                    w_refill = 1'b1;
                end else if (!s_v) begin
                    w_invalid = 1'b1;
                end else begin
                    w_paddr    = {s_pfn, r_vaddr[11:0]};
                    w_cached   = (s_c == C_CACHED);
                    w_modified = r_store & ~s_d;
                    // A concurrent flush must not leave a stale entry behind.
                    w_fill     = ~flush;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered request, source of the joint-TLB query and fill key.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vaddr <= 32'h0000_0000;
            r_asid  <= 8'h00;
            r_store <= 1'b0;
        end else if (w_capture) begin
            r_vaddr <= req_vaddr;
            r_asid  <= req_asid;
            r_store <= req_store;
        end
    end

    // Registered handshake and response fields; fields hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_paddr      <= 32'h0000_0000;
            r_refill     <= 1'b0;
            r_invalid    <= 1'b0;
            r_modified   <= 1'b0;
            r_cached     <= 1'b0;
        end else begin
            r_req_ready  <= (w_next_state == ST_IDLE);
            r_resp_valid <= (w_next_state == ST_RESP);
            if (w_load_resp) begin
                r_paddr    <= w_paddr;
                r_refill   <= w_refill;
                r_invalid  <= w_invalid;
                r_modified <= w_modified;
                r_cached   <= w_cached;
            end
        end
    end

    // Round-robin victim pointer; advances only on a real fill, survives flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_fill) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

`ifdef UTLB_PERF_EN
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;

    // Hit/miss event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_hit  <= 32'd0;
            r_perf_miss <= 32'd0;
        end else begin
            if (w_hit_accept) begin
                r_perf_hit <= r_perf_hit + 32'd1;
            end
            if (r_state == ST_WALK) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
        end
    end

    assign perf_hit  = r_perf_hit;
    assign perf_miss = r_perf_miss;
`endif

endmodule
